window_match_sched: RTL and testbench
=====================================

// Module: window_match_sched
// PURPOSE
//  Parametrised scheduler for stereo window matching. Per start it walks one f window (WIN x WIN) against
//  NDISP candidate g windows, NDISP/LANES per lane, lanes in parallel. Drives the pixel-RAM address, the f
//  shift chain, one-hot lane strobes and the row/clear pulses to the lane units. Accumulates sum(f) and
//  sum(f^2) internally, then hands per-group results downstream with valid/ready. Sits between pixel RAM and lane array.
// PARAMETERS
//  PIX_W   3   pixel width (unsigned)
//  WIN     16  window side; columns and rows per f window
//  NDISP   64  disparity candidates; must be a multiple of LANES
//  LANES   16  parallel match lanes
//  RD_LAT  1   pixel-RAM read latency in cycles (>=1)
//  derived: NCOL=WIN+NDISP-1; FSUM_W=$clog2(WIN*WIN*(2**PIX_W-1)+1); F2SUM_W=$clog2(WIN*WIN*(2**PIX_W-1)**2+1)
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rst_n      in   1               asynchronous active-low reset
//  start      in   1               begin one window; sampled only in IDLE
//  busy       out  1               high from start acceptance until DONE
//  rd_en      out  1               pixel-RAM read strobe (one per column step)
//  rd_xf      out  clog2(WIN)      f column = col mod WIN
//  rd_xg      out  clog2(NCOL)     g column = col
//  rd_y       out  clog2(WIN)      current row
//  f_pix      in   PIX_W           f pixel, valid RD_LAT cycles after rd_en
//  f_chain    out  LANES*PIX_W     f shift chain; lane k reads slice k
//  lane_sel   out  LANES           one-hot, bit (col mod LANES)
//  lane_work  out  1               one-cycle compute strobe to lanes
//  clear      out  1               one-cycle pulse: lanes clear accumulators
//  line_start out  1               one-cycle pulse at each row start
//  fsum       out  FSUM_W          sum of f over window
//  f2sum      out  F2SUM_W         sum of f^2 over window
//  res_valid  out  1               group result presented
//  res_ready  in   1               downstream accepts group
//  res_grp    out  clog2(NDISP/LANES) group index being presented
//  done       out  1               one-cycle pulse after last group accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, f_chain 0, counters 0. Reset mid-window discards everything immediately.
//  FSM: IDLE -start-> CLEAR(clear=1, fsum/f2sum<=0) -> LINE(line_start=1, col<=0) -> FETCH(rd_en=1 first cycle,
//   wait RD_LAT) -> SHIFT(f_chain<<=f_pix into slice 0; lane_sel set) -> CALC(lane_work=1; if col<WIN:
//   fsum+=f_pix, f2sum+=f_pix*f_pix) -> STEP.
//  STEP: col<NCOL-1: col++ -> FETCH. col==NCOL-1: row<WIN-1: row++ -> LINE; else -> DRAIN.
//  Column cost RD_LAT+3 cycles; row cost NCOL*(RD_LAT+3)+1; window = 1+WIN*row cost cycles before DRAIN.
//  f_pix captured in SHIFT is held and reused in CALC; rd_* addresses stable from FETCH through STEP.
//  DRAIN: res_valid=1, res_grp=g (from 0). Transfer on res_valid&&res_ready; g++; after g==NDISP/LANES-1 -> DONE.
//   res_grp/res_valid stable while stalled; fsum/f2sum stable from DRAIN until next CLEAR.
//  DONE: done=1 one cycle, busy=0 next cycle -> IDLE.
//  start outside IDLE ignored (no queueing). start and rst_n deassert same edge: start ignored.
//  Sums sized so no overflow at max pixel; lane_sel wraps LANES-1 -> 0 at column wrap; row restarts lane_sel at bit 0.
// CONFIGURATION
//  WMS_AUTO_RESTART_EN defined: DONE -> CLEAR directly (busy stays 1, start ignored), continuous windows.
//  Undefined: DONE -> IDLE, next window only on start.
// STRUCTURE
//  Package wms_pkg: state enum (IDLE,CLEAR,LINE,FETCH,SHIFT,CALC,STEP,DRAIN,DONE), width functions for
//   FSUM_W/F2SUM_W/NCOL.
//  Sub-module wms_fsum_acc: fsum/f2sum accumulator with clear and enable; rest of FSM in top.
// TESTING (WIN=4, NDISP=8, LANES=4, RD_LAT=1, PIX_W=3 unless noted)
//  f_pix=7 constant, start pulse -> fsum=112, f2sum=784; first res_valid 181 cycles after CLEAR.
//  f_pix=col value -> lane_sel 0001,0010,0100,1000,0001...; line_start 4 pulses; rd_xg 0..10 each row.
//  DRAIN with res_ready low 5 cycles -> res_grp=0 held, valid held; two accepts -> done pulses, busy drops.
//  rst_n low during FETCH of row 2 -> all outputs 0 asynchronously; next start runs full window correctly.
//  start asserted while busy -> ignored; with WMS_AUTO_RESTART_EN -> clear pulse one cycle after done.
//  Default params, f_pix=7 -> fsum=1792, f2sum=12544 (no overflow), res_grp 0..3.

Source files
------------

// File: rtl/wms_pkg.sv
// wms_pkg: state encoding and width helpers shared by window_match_sched
package wms_pkg;
    typedef enum logic [3:0] {IDLE, CLEAR, LINE, FETCH, SHIFT, CALC, STEP, DRAIN, DONE} state_t;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int ncol_f(input int win, input int ndisp);
        return win + ndisp - 1;
    endfunction
    function automatic int fsum_w(input int win, input int pix_w);
        return $clog2(win * win * (2 ** pix_w - 1) + 1);
    endfunction
    function automatic int f2sum_w(input int win, input int pix_w);
        return $clog2(win * win * (2 ** pix_w - 1) ** 2 + 1);
    endfunction
endpackage

// File: rtl/wms_fsum_acc.sv
// wms_fsum_acc: running sum(f) and sum(f^2) with synchronous clear and enable
module wms_fsum_acc #(
    parameter int PIX_W   = 3,
    parameter int FSUM_W  = 7,
    parameter int F2SUM_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [PIX_W-1:0]   pix,
    output logic [FSUM_W-1:0]  fsum,
    output logic [F2SUM_W-1:0] f2sum
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fsum  <= '0;
            f2sum <= '0;
        end else if (clr) begin
            fsum  <= '0;
            f2sum <= '0;
        end else if (en) begin
            fsum  <= fsum + FSUM_W'(pix);
            f2sum <= f2sum + F2SUM_W'(pix) * F2SUM_W'(pix);
        end
endmodule

// File: rtl/window_match_sched.sv
// window_match_sched: walks one f window against NDISP g windows over LANES parallel lanes.
// WMS_AUTO_RESTART_EN: DONE chains straight into CLEAR for continuous windows.
module window_match_sched
    import wms_pkg::*;
#(
    parameter int PIX_W  = 3,
    parameter int WIN    = 16,
    parameter int NDISP  = 64,
    parameter int LANES  = 16,
    parameter int RD_LAT = 1,
    localparam int NCOL    = ncol_f(WIN, NDISP),
    localparam int NGRP    = NDISP / LANES,
    localparam int FSUM_W  = fsum_w(WIN, PIX_W),
    localparam int F2SUM_W = f2sum_w(WIN, PIX_W),
    localparam int XF_W    = cw(WIN),
    localparam int XG_W    = cw(NCOL),
    localparam int GRP_W   = cw(NGRP),
    localparam int CH_W    = LANES * PIX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               rd_en,
    output logic [XF_W-1:0]    rd_xf,
    output logic [XG_W-1:0]    rd_xg,
    output logic [XF_W-1:0]    rd_y,
    input  logic [PIX_W-1:0]   f_pix,
    output logic [CH_W-1:0]    f_chain,
    output logic [LANES-1:0]   lane_sel,
    output logic               lane_work,
    output logic               clear,
    output logic               line_start,
    output logic [FSUM_W-1:0]  fsum,
    output logic [F2SUM_W-1:0] f2sum,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [GRP_W-1:0]   res_grp,
    output logic               done
);
    localparam int FC_W = cw(RD_LAT);
    state_t state, nxt;
    logic [XG_W-1:0] col;
    logic [XF_W-1:0] row;
    logic [FC_W-1:0] fcnt;
    logic [GRP_W-1:0] grp;
    logic [PIX_W-1:0] pix;
    logic armed, fetch_last, last_col, last_row, last_grp;
    assign fetch_last = fcnt == FC_W'(RD_LAT - 1);
    assign last_col   = col == XG_W'(NCOL - 1);
    assign last_row   = row == XF_W'(WIN - 1);
    assign last_grp   = grp == GRP_W'(NGRP - 1);
    assign rd_xg      = col;
    assign rd_y       = row;
    assign rd_xf      = XF_W'(32'(col) % WIN);
    assign res_grp    = grp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = (start && armed) ? CLEAR : IDLE;
            CLEAR: nxt = LINE;
            LINE:  nxt = FETCH;
            FETCH: nxt = fetch_last ? SHIFT : FETCH;
            SHIFT: nxt = CALC;
            CALC:  nxt = STEP;
            STEP:  nxt = !last_col ? FETCH : !last_row ? LINE : DRAIN;
            DRAIN: nxt = (res_ready && last_grp) ? DONE : DRAIN;
`ifdef WMS_AUTO_RESTART_EN
            DONE:  nxt = CLEAR;
`else
            DONE:  nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy       = state != IDLE;
        clear      = state == CLEAR;
        line_start = state == LINE;
        rd_en      = state == FETCH && fcnt == '0;
        lane_work  = state == CALC;
        res_valid  = state == DRAIN;
        done       = state == DONE;
    end
    // armed blocks a start that coincides with the reset-release edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            fcnt     <= '0;
            grp      <= '0;
            pix      <= '0;
            f_chain  <= '0;
            lane_sel <= '0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            fcnt  <= (state == FETCH && !fetch_last) ? fcnt + 1'b1 : '0;
            if (state == CLEAR) begin
                row <= '0;
                grp <= '0;
            end
            if (state == LINE) col <= '0;
            if (state == SHIFT) begin
                pix      <= f_pix;
                f_chain  <= (f_chain << PIX_W) | CH_W'(f_pix);
                lane_sel <= LANES'(1) << (32'(col) % LANES);
            end
            if (state == STEP) begin
                if (!last_col) col <= col + 1'b1;
                else if (!last_row) row <= row + 1'b1;
            end
            if (res_valid && res_ready && !last_grp) grp <= grp + 1'b1;
        end
    wms_fsum_acc #(.PIX_W(PIX_W), .FSUM_W(FSUM_W), .F2SUM_W(F2SUM_W)) u_acc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == CLEAR),
        .en   (state == CALC && 32'(col) < WIN),
        .pix  (pix),
        .fsum (fsum),
        .f2sum(f2sum)
    );
endmodule

// File: tb/tb_window_match_sched.sv
// tb_window_match_sched: directed checks on a small instance (WIN=4,NDISP=8,LANES=4) and a default-size one.
`timescale 1ns/1ps
module tb_window_match_sched;
    logic clk = 0, rst_n = 0, start = 0, res_ready = 0, mode = 0;
    logic [2:0] f_pix = 0;
    logic busy, rd_en, lane_work, clear, line_start, res_valid, done;
    logic [1:0] rd_xf, rd_y;
    logic [3:0] rd_xg, lane_sel;
    logic [11:0] f_chain;
    logic [6:0] fsum;
    logic [9:0] f2sum;
    logic [0:0] res_grp;
    logic start2 = 0, ready2 = 0;
    logic [2:0] f_pix2 = 3'd7;
    logic busy2, rd_en2, lane_work2, clear2, line_start2, res_valid2, done2;
    logic [3:0] rd_xf2, rd_y2;
    logic [6:0] rd_xg2;
    logic [47:0] f_chain2;
    logic [15:0] lane_sel2;
    logic [10:0] fsum2;
    logic [13:0] f2sum2;
    logic [1:0] res_grp2;
    int checks = 0, errors = 0;
    int cyc, lines, reads, works, clears, n;
    always #5 clk = ~clk;
    window_match_sched #(.PIX_W(3), .WIN(4), .NDISP(8), .LANES(4), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .rd_en(rd_en), .rd_xf(rd_xf),
        .rd_xg(rd_xg), .rd_y(rd_y), .f_pix(f_pix), .f_chain(f_chain), .lane_sel(lane_sel),
        .lane_work(lane_work), .clear(clear), .line_start(line_start), .fsum(fsum), .f2sum(f2sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_grp(res_grp), .done(done)
    );
    window_match_sched u_big (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .rd_en(rd_en2), .rd_xf(rd_xf2),
        .rd_xg(rd_xg2), .rd_y(rd_y2), .f_pix(f_pix2), .f_chain(f_chain2), .lane_sel(lane_sel2),
        .lane_work(lane_work2), .clear(clear2), .line_start(line_start2), .fsum(fsum2), .f2sum(f2sum2),
        .res_valid(res_valid2), .res_ready(ready2), .res_grp(res_grp2), .done(done2)
    );
    // pixel RAM with one cycle of read latency; mode 1 returns xf+y
    always @(posedge clk) if (rd_en) f_pix <= mode ? 3'(rd_xf) + 3'(rd_y) : 3'd7;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run_small(input bit hold_start);
        int k;
        k = 0; cyc = 0; lines = 0; reads = 0; works = 0; clears = 0;
        while (!res_valid && cyc < 1000) begin
            start = hold_start && cyc >= 10 && cyc < 30;
            tick;
            cyc++;
            if (line_start) begin
                chk("rd_y_at_line", 64'(rd_y), 64'(lines));
                lines++;
                k = 0;
            end
            if (rd_en) reads++;
            if (clear) clears++;
            if (lane_work) begin
                chk("lane_sel", 64'(lane_sel), 64'(4'b1 << (k % 4)));
                chk("rd_xg", 64'(rd_xg), 64'(k));
                chk("rd_xf", 64'(rd_xf), 64'(k % 4));
                works++;
                k++;
            end
        end
        start = 0;
    endtask
    task automatic settle;
`ifdef WMS_AUTO_RESTART_EN
        chk("restart_clear", 64'(clear), 64'd1);
        chk("restart_busy", 64'(busy), 64'd1);
        rst_n = 0;
        tick;
        rst_n = 1;
        tick;
        tick;
`else
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_clear", 64'(clear), 64'd0);
`endif
    endtask
    initial begin
        tick;
        tick;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({rd_en, lane_work, clear, line_start, res_valid, done}), 64'd0);
        chk("rst_chain", 64'(f_chain), 64'd0);
        chk("rst_lane_sel", 64'(lane_sel), 64'd0);
        chk("rst_sums", 64'({fsum, f2sum}), 64'd0);
        chk("rst_addr", 64'({rd_xg, rd_xf, rd_y, res_grp}), 64'd0);
        chk("rst_big_busy", 64'(busy2), 64'd0);
        rst_n = 1;
        tick;
        tick;
        // constant pixel 7
        start = 1;
        tick;
        start = 0;
        chk("t1_clear", 64'(clear), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        run_small(0);
        chk("t1_latency", 64'(cyc), 64'd181);
        chk("t1_lines", 64'(lines), 64'd4);
        chk("t1_reads", 64'(reads), 64'd44);
        chk("t1_works", 64'(works), 64'd44);
        chk("t1_no_clear", 64'(clears), 64'd0);
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_grp0", 64'(res_grp), 64'd0);
        chk("t1_fsum", 64'(fsum), 64'd112);
        chk("t1_f2sum", 64'(f2sum), 64'd784);
        chk("t1_chain", 64'(f_chain), 64'hFFF);
        repeat (5) tick;
        chk("t1_stall_valid", 64'(res_valid), 64'd1);
        chk("t1_stall_grp", 64'(res_grp), 64'd0);
        chk("t1_stall_done", 64'(done), 64'd0);
        res_ready = 1;
        tick;
        chk("t1_grp1", 64'(res_grp), 64'd1);
        chk("t1_grp1_valid", 64'(res_valid), 64'd1);
        chk("t1_grp1_done", 64'(done), 64'd0);
        tick;
        res_ready = 0;
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_done_busy", 64'(busy), 64'd1);
        chk("t1_done_valid", 64'(res_valid), 64'd0);
        chk("t1_done_fsum", 64'(fsum), 64'd112);
        tick;
        chk("t1_done_pulse", 64'(done), 64'd0);
        settle;
        // pixel xf+y, start held high while busy
        mode = 1;
        start = 1;
        tick;
        start = 0;
        chk("t2_clear", 64'(clear), 64'd1);
        run_small(1);
        chk("t2_latency", 64'(cyc), 64'd181);
        chk("t2_lines", 64'(lines), 64'd4);
        chk("t2_no_clear", 64'(clears), 64'd0);
        chk("t2_fsum", 64'(fsum), 64'd48);
        chk("t2_f2sum", 64'(f2sum), 64'd184);
        chk("t2_chain", 64'(f_chain), 64'({3'd6, 3'd3, 3'd4, 3'd5}));
        res_ready = 1;
        tick;
        chk("t2_grp1", 64'(res_grp), 64'd1);
        tick;
        res_ready = 0;
        chk("t2_done", 64'(done), 64'd1);
        tick;
        settle;
`ifndef WMS_AUTO_RESTART_EN
        repeat (3) tick;
        chk("t2_no_queue", 64'({busy, clear}), 64'd0);
`endif
        // asynchronous reset during row-2 fetch
        mode = 0;
        start = 1;
        tick;
        start = 0;
        n = 0;
        while (!(rd_en && rd_y == 2'd2) && n < 1000) begin
            tick;
            n++;
        end
        chk("t3_reach_row2", 64'(rd_en && rd_y == 2'd2), 64'd1);
        rst_n = 0;
        #1;
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_strobes", 64'({rd_en, lane_work, clear, line_start, res_valid, done}), 64'd0);
        chk("t3_addr", 64'({rd_xg, rd_xf, rd_y}), 64'd0);
        chk("t3_chain", 64'({f_chain, lane_sel}), 64'd0);
        chk("t3_sums", 64'({fsum, f2sum}), 64'd0);
        tick;
        rst_n = 1;
        tick;
        tick;
        start = 1;
        tick;
        start = 0;
        run_small(0);
        chk("t3_latency", 64'(cyc), 64'd181);
        chk("t3_fsum", 64'(fsum), 64'd112);
        chk("t3_f2sum", 64'(f2sum), 64'd784);
        res_ready = 1;
        tick;
        tick;
        res_ready = 0;
        chk("t3_done", 64'(done), 64'd1);
        tick;
        settle;
        // default-size instance, pixel 7
        start2 = 1;
        tick;
        start2 = 0;
        chk("t4_clear", 64'(clear2), 64'd1);
        n = 0;
        while (!res_valid2 && n < 6000) begin
            tick;
            n++;
        end
        chk("t4_latency", 64'(n), 64'd5073);
        chk("t4_fsum", 64'(fsum2), 64'd1792);
        chk("t4_f2sum", 64'(f2sum2), 64'd12544);
        ready2 = 1;
        for (int g = 0; g < 4; g++) begin
            chk("t4_grp", 64'(res_grp2), 64'(g));
            chk("t4_valid", 64'(res_valid2), 64'd1);
            tick;
        end
        ready2 = 0;
        chk("t4_done", 64'(done2), 64'd1);
        tick;
        chk("t4_done_pulse", 64'(done2), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
